logic_unit_sequencer: RTL
=========================

// Module: logic_unit_sequencer
// PURPOSE
//  Control-side driver of the logic unit's ALUOp/Update_UC interface. Accepts one ALU/shift/branch
//  request from the main control FSM, holds ALUOp stable for the op's latency (clocked ALUcontrol
//  plus clocked shifter need multi-cycle), then captures ALUOut/flags and signals completion.
//  Lives inside the control unit; all logic-unit outputs are consumed only through this block.
// PARAMETERS
//  ALU_LAT    1  cycles ALUOp held before capture for arithmetic/logic/slt ops (>=1)
//  SHIFT_LAT  3  cycles ALUOp held before capture for shift ops (load + shift + settle; >=1)
//  BR_LAT     1  cycles ALUOp held before capture for branch-compare ops (>=1)
// PORTS
//  clk           in   1   system clock
//  reset         in   1   asynchronous, active-high reset
//  req_valid     in   1   control FSM presents an op
//  req_ready     out  1   sequencer idle, request accepted when req_valid&&req_ready
//  req_op        in   4   op code (lu_pkg encoding, identical to ALUOp)
//  ALUOp         out  4   to logic unit
//  lu_ALUOut     in   32  logic unit result
//  lu_OVERFLOW   in   1   logic unit overflow flag
//  lu_ZERO       in   1   logic unit zero flag
//  lu_Update_UC  in   1   logic unit branch-condition result
//  done          out  1   1-cycle pulse: result/flags valid
//  result        out  32  captured lu_ALUOut
//  res_we        out  1   1-cycle pulse with done when result is to be written back
//  zero_q        out  1   captured lu_ZERO
//  branch_taken  out  1   captured lu_Update_UC, branch ops only, else 0
//  exc_ovf       out  1   sticky overflow exception (see CONFIGURATION)
//  exc_clr       in   1   clears exc_ovf
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, ALUOp=OP_NOP(4'h0), req_ready=1, done=0, res_we=0,
//   result=0, zero_q=0, branch_taken=0, exc_ovf=0, cnt=0.
//  States: IDLE -> EXEC -> CAPTURE -> IDLE.
//   IDLE: req_ready=1; on accept latch req_op, drive ALUOp=req_op from next cycle, load
//    cnt=LAT(op)-1, go EXEC. Unknown/NOP op: accepted, done pulses after 1 cycle, res_we=0.
//   EXEC: req_ready=0, ALUOp held; cnt decrements each cycle; cnt==0 -> CAPTURE.
//   CAPTURE: sample lu_* into regs; done=1 next cycle concurrent with return to IDLE;
//    ALUOp returns to OP_NOP in IDLE.
//  Latency: accept at cycle T -> done at T+LAT(op)+2. Back-to-back: new accept allowed in the
//   cycle done is high (IDLE, ready=1).
//  req_valid while busy is ignored (no queueing); control FSM must hold it until ready.
//  res_we=1 with done for ADD/SUB/AND/SLT/shift/INC; 0 for branch ops and NOP.
//  branch_taken updated only on branch ops, cleared to 0 on any other completed op.
//  exc_clr and a new overflow in the same cycle: set wins.
//  Reset mid-EXEC aborts op silently: no done, no res_we.
// CONFIGURATION
//  OVF_TRAP_EN defined: overflow on ADD/SUB sets exc_ovf (sticky) and forces res_we=0 for that op.
//  OVF_TRAP_EN undefined: lu_OVERFLOW ignored, exc_ovf tied 0, res_we per op class only.
// STRUCTURE
//  lu_pkg: ALUOp constants OP_NOP=0 ADD=1 SUB=2 AND=3 SLT=4 SLL=5 SRL=6 SRA=7 SLLV=8 SRLV=9
//   SRAV=A BEQ=B BNE=C BLE=D BGT=E INC=F; state enum; op-class function (alu/shift/branch/nop).
//  One sub-module: lu_latency_lut (op -> class, latency, writes_back), combinational.
//  Sequencer FSM, counter and capture regs in this module.
// TESTING
//  ADD, lu_ALUOut=32'h0000_0005 -> done at T+3, result=5, res_we=1, ALUOp=1 for cycles T+1..T+2.
//  SLL (SHIFT_LAT=3), ALUOut=32'h0000_0010 -> ALUOp=5 held 4 cycles, done at T+5, result=32'h10.
//  BEQ with lu_Update_UC=1 -> done, branch_taken=1, res_we=0; next AND -> branch_taken=0.
//  SUB with lu_OVERFLOW=1: EN -> exc_ovf=1, res_we=0; exc_clr -> exc_ovf=0; no EN -> res_we=1.
//  reset asserted mid-EXEC of SRA -> outputs at reset values immediately, no done pulse.
//  req_valid held during busy -> single accept; second req accepted in done cycle.

Source files
------------

// File: rtl/lu_pkg.sv
// Shared types and constants for the logic-unit sequencer: ALUOp encoding, op classes, FSM states.
package lu_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OP_W-1:0] OP_AND  = 4'h3;
    localparam logic [OP_W-1:0] OP_SLT  = 4'h4;
    localparam logic [OP_W-1:0] OP_SLL  = 4'h5;
    localparam logic [OP_W-1:0] OP_SRL  = 4'h6;
    localparam logic [OP_W-1:0] OP_SRA  = 4'h7;
    localparam logic [OP_W-1:0] OP_SLLV = 4'h8;
    localparam logic [OP_W-1:0] OP_SRLV = 4'h9;
    localparam logic [OP_W-1:0] OP_SRAV = 4'hA;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'hB;
    localparam logic [OP_W-1:0] OP_BNE  = 4'hC;
    localparam logic [OP_W-1:0] OP_BLE  = 4'hD;
    localparam logic [OP_W-1:0] OP_BGT  = 4'hE;
    localparam logic [OP_W-1:0] OP_INC  = 4'hF;

    typedef enum logic [1:0] {
        CLS_NOP    = 2'd0,
        CLS_ALU    = 2'd1,
        CLS_SHIFT  = 2'd2,
        CLS_BRANCH = 2'd3
    } op_class_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    typedef struct packed {
        op_class_e          cls;
        logic [CNT_W-1:0]   lat;
        logic               wb;
    } lut_info_t;

    function automatic op_class_e op_class(input logic [OP_W-1:0] op);
        op_class_e cls;
        cls = CLS_NOP;
        if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_SLT || op == OP_INC)
            cls = CLS_ALU;
        else if (op >= OP_SLL && op <= OP_SRAV)
            cls = CLS_SHIFT;
        else if (op >= OP_BEQ && op <= OP_BGT)
            cls = CLS_BRANCH;
        return cls;
    endfunction

endpackage

// File: rtl/lu_latency_lut.sv
// Combinational op decode: class, ALUOp hold latency and write-back flag for each op code.
module lu_latency_lut
    import lu_pkg::*;
#(
    parameter int unsigned ALU_LAT   = 1,
    parameter int unsigned SHIFT_LAT = 3,
    parameter int unsigned BR_LAT    = 1
) (
    input  logic [OP_W-1:0] i_op,
    output lut_info_t       o_info_c
);

    always_comb begin
        o_info_c     = '{cls: CLS_NOP, lat: CNT_W'(1), wb: 1'b0};
        o_info_c.cls = op_class(i_op);
        case (o_info_c.cls)
            CLS_ALU: begin
                o_info_c.lat = CNT_W'(ALU_LAT);
                o_info_c.wb  = 1'b1;
            end
            CLS_SHIFT: begin
                o_info_c.lat = CNT_W'(SHIFT_LAT);
                o_info_c.wb  = 1'b1;
            end
            CLS_BRANCH: begin
                o_info_c.lat = CNT_W'(BR_LAT);
                o_info_c.wb  = 1'b0;
            end
            default: begin
                o_info_c.lat = CNT_W'(1);
                o_info_c.wb  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/logic_unit_sequencer.sv
// Holds ALUOp for each op's latency, captures logic-unit result/flags and pulses done.
// Optional feature macro OVF_TRAP_EN: ADD/SUB overflow sets sticky exc_ovf and suppresses write-back.
module logic_unit_sequencer
    import lu_pkg::*;
#(
    parameter int unsigned ALU_LAT   = 1,
    parameter int unsigned SHIFT_LAT = 3,
    parameter int unsigned BR_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    output logic [OP_W-1:0]   ALUOp,
    input  logic [DATA_W-1:0] lu_ALUOut,
    input  logic              lu_OVERFLOW,
    input  logic              lu_ZERO,
    input  logic              lu_Update_UC,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              res_we,
    output logic              zero_q,
    output logic              branch_taken,
    output logic              exc_ovf,
    input  logic              exc_clr
);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    op_class_e        r_cls;
    logic             r_wb;
    lut_info_t        w_info;
    logic             w_ovf_trap;

    lu_latency_lut #(
        .ALU_LAT   (ALU_LAT),
        .SHIFT_LAT (SHIFT_LAT),
        .BR_LAT    (BR_LAT)
    ) u_lut (
        .i_op     (req_op),
        .o_info_c (w_info)
    );

`ifdef OVF_TRAP_EN
    // ALUOp still holds the op during CAPTURE, so it identifies ADD/SUB there.
    assign w_ovf_trap = (ALUOp == OP_ADD || ALUOp == OP_SUB) && lu_OVERFLOW;

    // Sticky exception; a new overflow wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            exc_ovf <= 1'b0;
        else if (r_state == ST_CAPTURE && w_ovf_trap)
            exc_ovf <= 1'b1;
        else if (exc_clr)
            exc_ovf <= 1'b0;
    end
`else
    logic w_cfg_unused;
    assign w_cfg_unused = lu_OVERFLOW | exc_clr;
    assign w_ovf_trap   = 1'b0;
    assign exc_ovf      = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_cls        <= CLS_NOP;
            r_wb         <= 1'b0;
            ALUOp        <= OP_NOP;
            req_ready    <= 1'b1;
            done         <= 1'b0;
            res_we       <= 1'b0;
            result       <= '0;
            zero_q       <= 1'b0;
            branch_taken <= 1'b0;
        end else begin
            done   <= 1'b0;
            res_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (w_info.cls == CLS_NOP) begin
                            // NOP completes without touching the logic unit.
                            done         <= 1'b1;
                            branch_taken <= 1'b0;
                        end else begin
                            ALUOp     <= req_op;
                            r_cnt     <= w_info.lat - CNT_W'(1);
                            r_cls     <= w_info.cls;
                            r_wb      <= w_info.wb;
                            req_ready <= 1'b0;
                            r_state   <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (r_cnt == '0)
                        r_state <= ST_CAPTURE;
                    else
                        r_cnt <= r_cnt - CNT_W'(1);
                end
                ST_CAPTURE: begin
                    result       <= lu_ALUOut;
                    zero_q       <= lu_ZERO;
                    branch_taken <= (r_cls == CLS_BRANCH) ? lu_Update_UC : 1'b0;
                    res_we       <= r_wb & ~w_ovf_trap;
                    done         <= 1'b1;
                    ALUOp        <= OP_NOP;
                    req_ready    <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    ALUOp     <= OP_NOP;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
